// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 16-entry register file.
//   DEPTH    : number of entries
//   ADDR_W   : entry index width
//   state_e  : controller states (IDLE, CLEAR)
//   CLR_LAST : index of the last entry zeroed by a clear sequence
package reg_file_pkg;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   localparam logic [ADDR_W-1:0] CLR_LAST = 4'd15;

endpackage : reg_file_pkg

// File: rtl/onehot_enc_16.sv
// Combinational one-hot encoder for a 16-bit select vector.
//   vec       : input select vector
//   idx_c     : index of the set bit (valid only when one_hot_c = 1)
//   one_hot_c : exactly one bit of vec is set
//   multi_c   : more than one bit of vec is set
module onehot_enc_16
   import reg_file_pkg::*;
(
   input  logic [DEPTH-1:0]  vec,
   output logic [ADDR_W-1:0] idx_c,
   output logic              one_hot_c,
   output logic              multi_c
);

   logic seen;

   // Scan all bits; OR-ing indices gives the right answer when only one is set.
   always_comb begin
      idx_c   = '0;
      seen    = 1'b0;
      multi_c = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (vec[i]) begin
            if (seen) multi_c = 1'b1;
            seen  = 1'b1;
            idx_c = idx_c | ADDR_W'(i);
         end
      end
      one_hot_c = seen & ~multi_c;
   end

endmodule : onehot_enc_16

// File: rtl/reg_file_16.sv
// 16-entry register file with one-hot write select, two registered read
// ports and a sequenced clear-all (one entry per cycle).
//   clk, rst           : clock, synchronous active-high reset
//   wr_valid/wr_ready  : write handshake; ready only while not clearing
//   we_onehot, wdata   : one-hot entry select and write data
//   raddr_a/b, rdata_a/b : read addresses and registered read data (latency 1)
//   clr_req, clr_busy  : start a clear / clear in progress
//   err_multi          : sticky, set by a fired write with >1 enable bit
// Build option: REG_FILE_WRITE_BYPASS_EN forwards same-cycle write data to
// a read port addressing the written entry.
module reg_file_16
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DEPTH-1:0]  we_onehot,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              err_multi
);

   state_e              state, state_nxt;
   logic [ADDR_W-1:0]   cnt, cnt_nxt;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic [ADDR_W-1:0]   wr_idx;
   logic                wr_one_hot;
   logic                wr_multi;
   logic                wr_en;
   logic                err_set;
   logic                clr_en;
   logic                byp_a;
   logic                byp_b;
   logic [DATA_W-1:0]   rdata_a_nxt;
   logic [DATA_W-1:0]   rdata_b_nxt;

   onehot_enc_16 u_enc (
      .vec       (we_onehot),
      .idx_c     (wr_idx),
      .one_hot_c (wr_one_hot),
      .multi_c   (wr_multi)
   );

   // Both flags are pure decodes of the state register.
   assign wr_ready = (state == IDLE);
   assign clr_busy = (state == CLEAR);

   // Next-state and datapath controls.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wr_en     = 1'b0;
      err_set   = 1'b0;
      clr_en    = 1'b0;
      case (state)
         IDLE: begin
            wr_en   = wr_valid & wr_one_hot;
            err_set = wr_valid & wr_multi;
            if (clr_req) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            clr_en  = 1'b1;
            cnt_nxt = cnt + ADDR_W'(1);
            if (cnt == CLR_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef REG_FILE_WRITE_BYPASS_EN
   assign byp_a = wr_en & (wr_idx == raddr_a);
   assign byp_b = wr_en & (wr_idx == raddr_b);
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif

   // Read data sampled from storage before this edge's update.
   assign rdata_a_nxt = byp_a ? wdata : mem[raddr_a];
   assign rdata_b_nxt = byp_b ? wdata : mem[raddr_b];

   // State register and clear counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Storage, read registers and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         rdata_a   <= '0;
         rdata_b   <= '0;
         err_multi <= 1'b0;
      end else begin
         rdata_a <= rdata_a_nxt;
         rdata_b <= rdata_b_nxt;
         if (err_set) err_multi <= 1'b1;
         // Writes only fire in IDLE and zeroing only in CLEAR, so they never collide.
         if (wr_en)  mem[wr_idx] <= wdata;
         if (clr_en) mem[cnt]    <= '0;
      end
   end

endmodule : reg_file_16

// File: tb/tb_reg_file_16.sv
// Self-checking bench for reg_file_16: directed steps plus random traffic,
// compared every cycle against a behavioural model of the register file.
module tb_reg_file_16;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic        wr_ready;
   logic [15:0] we_onehot;
   logic [7:0]  wdata;
   logic [3:0]  raddr_a;
   logic [3:0]  raddr_b;
   logic [7:0]  rdata_a;
   logic [7:0]  rdata_b;
   logic        clr_req;
   logic        clr_busy;
   logic        err_multi;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   logic [7:0] mem_m [16];
   bit         busy_m;
   bit         err_m;
   int         clr_idx;
   logic [7:0] rda_m;
   logic [7:0] rdb_m;

   reg_file_16 #(.DATA_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .we_onehot (we_onehot),
      .wdata     (wdata),
      .raddr_a   (raddr_a),
      .raddr_b   (raddr_b),
      .rdata_a   (rdata_a),
      .rdata_b   (rdata_b),
      .clr_req   (clr_req),
      .clr_busy  (clr_busy),
      .err_multi (err_multi)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Apply the rules of one clock edge to the model using the current inputs.
   task automatic model_edge();
      bit fire;
      int n;
      if (rst) begin
         foreach (mem_m[i]) mem_m[i] = 8'h00;
         busy_m  = 1'b0;
         err_m   = 1'b0;
         clr_idx = 0;
         rda_m   = 8'h00;
         rdb_m   = 8'h00;
      end else begin
         fire  = wr_valid && !busy_m;
         n     = $countones(we_onehot);
         rda_m = mem_m[raddr_a];
         rdb_m = mem_m[raddr_b];
`ifdef REG_FILE_WRITE_BYPASS_EN
         if (fire && n == 1 && we_onehot[raddr_a]) rda_m = wdata;
         if (fire && n == 1 && we_onehot[raddr_b]) rdb_m = wdata;
`endif
         if (fire && n == 1)
            for (int i = 0; i < 16; i++) if (we_onehot[i]) mem_m[i] = wdata;
         if (fire && n > 1) err_m = 1'b1;
         if (busy_m) begin
            mem_m[clr_idx] = 8'h00;
            clr_idx++;
            if (clr_idx == 16) begin
               busy_m  = 1'b0;
               clr_idx = 0;
            end
         end else if (clr_req) begin
            busy_m  = 1'b1;
            clr_idx = 0;
         end
      end
   endtask

   // One clock: update model, wait for the edge, compare all outputs.
   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      chk("rdata_a",   32'(rdata_a),   32'(rda_m));
      chk("rdata_b",   32'(rdata_b),   32'(rdb_m));
      chk("wr_ready",  32'(wr_ready),  32'(!busy_m));
      chk("clr_busy",  32'(clr_busy),  32'(busy_m));
      chk("err_multi", 32'(err_multi), 32'(err_m));
   endtask

   function automatic logic [15:0] rand_we();
      logic [15:0] v;
      case ($urandom_range(0, 9))
         0:       v = 16'h0000;
         1:       v = 16'($urandom);
         default: v = 16'(1) << $urandom_range(0, 15);
      endcase
      return v;
   endfunction

   task automatic rand_inputs(input bit allow_clr, input bit allow_rst);
      wr_valid  = 1'($urandom_range(0, 1));
      we_onehot = rand_we();
      wdata     = 8'($urandom);
      raddr_a   = 4'($urandom);
      raddr_b   = 4'($urandom);
      clr_req   = allow_clr && ($urandom_range(0, 19) == 0);
      rst       = allow_rst && ($urandom_range(0, 99) == 0);
   endtask

   task automatic idle_inputs();
      rst = 1'b0; wr_valid = 1'b0; we_onehot = 16'h0; wdata = 8'h0; clr_req = 1'b0;
   endtask

   initial begin
      int n;
      idle_inputs();
      raddr_a = 4'd0;
      raddr_b = 4'd15;
      busy_m = 1'b0; err_m = 1'b0; clr_idx = 0; rda_m = 8'h0; rdb_m = 8'h0;
      foreach (mem_m[i]) mem_m[i] = 8'h00;

      // Reset, then read entries 0 and 15
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      chk("rst_rdata_a",  32'(rdata_a),   32'h0);
      chk("rst_rdata_b",  32'(rdata_b),   32'h0);
      chk("rst_wr_ready", 32'(wr_ready),  32'h1);
      chk("rst_clr_busy", 32'(clr_busy),  32'h0);
      chk("rst_err",      32'(err_multi), 32'h0);

      // Basic write/read
      wr_valid = 1'b1; we_onehot = 16'h0020; wdata = 8'hA5;
      cycle();
      idle_inputs(); raddr_a = 4'd5;
      cycle();
      chk("basic_a5", 32'(rdata_a), 32'hA5);
      wr_valid = 1'b1; we_onehot = 16'h8000; wdata = 8'h3C;
      cycle();
      idle_inputs(); raddr_b = 4'd15;
      cycle();
      chk("basic_3c", 32'(rdata_b), 32'h3C);

      // Same-cycle read/write on entry 5
      raddr_a = 4'd5; wr_valid = 1'b1; we_onehot = 16'h0020; wdata = 8'h5A;
      cycle();
`ifdef REG_FILE_WRITE_BYPASS_EN
      chk("rw_same_next", 32'(rdata_a), 32'h5A);
`else
      chk("rw_same_next", 32'(rdata_a), 32'hA5);
`endif
      idle_inputs();
      cycle();
      chk("rw_same_after", 32'(rdata_a), 32'h5A);

      // Illegal multi-bit enable, then an empty enable
      raddr_a = 4'd0; raddr_b = 4'd1;
      wr_valid = 1'b1; we_onehot = 16'h0003; wdata = 8'hFF;
      cycle();
      chk("multi_err", 32'(err_multi), 32'h1);
      we_onehot = 16'h0000; wdata = 8'h77;
      cycle();
      chk("multi_e0", 32'(rdata_a), 32'h0);
      chk("multi_e1", 32'(rdata_b), 32'h0);
      idle_inputs();
      cycle();
      chk("multi_held", 32'(err_multi), 32'h1);

      // Random traffic without clears
      for (int k = 0; k < 200; k++) begin
         rand_inputs(1'b0, 1'b0);
         cycle();
      end

      // Fill every entry with 8'h11
      idle_inputs();
      for (int i = 0; i < 16; i++) begin
         wr_valid = 1'b1; we_onehot = 16'(1) << i; wdata = 8'h11;
         raddr_a = 4'($urandom); raddr_b = 4'($urandom);
         cycle();
      end

      // Clear request together with a write to entry 2
      wr_valid = 1'b1; we_onehot = 16'h0004; wdata = 8'h22; clr_req = 1'b1;
      cycle();
      idle_inputs();
      n = 0;
      for (int k = 0; k < 40 && clr_busy; k++) begin
         n++;
         chk("clr_wr_ready", 32'(wr_ready), 32'h0);
         wr_valid  = (k == 5);
         we_onehot = 16'h0100;
         wdata     = 8'h99;
         raddr_a   = 4'($urandom); raddr_b = 4'($urandom);
         cycle();
      end
      chk("clr_cycles", 32'(n), 32'd16);
      idle_inputs();
      for (int i = 0; i < 16; i += 2) begin
         raddr_a = 4'(i); raddr_b = 4'(i + 1);
         cycle();
         chk("clr_zero_a", 32'(rdata_a), 32'h0);
         chk("clr_zero_b", 32'(rdata_b), 32'h0);
      end
      chk("clr_idle", 32'(wr_ready), 32'h1);

      // Refill randomly, then reset at clear cycle 7
      for (int k = 0; k < 40; k++) begin
         rand_inputs(1'b0, 1'b0);
         cycle();
      end
      idle_inputs();
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      for (int k = 0; k < 7; k++) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rstclr_busy",  32'(clr_busy),  32'h0);
      chk("rstclr_ready", 32'(wr_ready),  32'h1);
      chk("rstclr_err",   32'(err_multi), 32'h0);
      for (int i = 0; i < 16; i += 2) begin
         raddr_a = 4'(i); raddr_b = 4'(i + 1);
         cycle();
         chk("rstclr_zero_a", 32'(rdata_a), 32'h0);
         chk("rstclr_zero_b", 32'(rdata_b), 32'h0);
      end

      // Held clear request: back-to-back clear sequences
      clr_req = 1'b1;
      for (int k = 0; k < 40; k++) cycle();
      idle_inputs();

      // Random traffic with clears and occasional reset
      for (int k = 0; k < 400; k++) begin
         rand_inputs(1'b1, 1'b1);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_reg_file_16
